vga_sync_gen: RTL and testbench

//  Generates VGA 640x480@60 Hz timing from the 100 MHz system clock. Produces pix_x, pix_y and

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_sync_gen_if.sv | 23 ++
 rtl/pixel_tick_div.sv | 42 ++++
 rtl/vga_sync_gen.sv | 140 ++++++++++++++
 tb/tb_vga_sync_gen.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vga_timing_pkg
// Description : 640x480@60 Hz VGA timing defaults, derived totals and sync
//               windows, plus the coordinate width used by the RGB selector
//               and the glyph renderers.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam int unsigned DEF_TICK_DIV  = 4;
  localparam int unsigned DEF_SYNC_DLY  = 1;

  localparam int unsigned H_TOTAL  = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned V_TOTAL  = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int unsigned HS_START = DEF_H_DISPLAY + DEF_H_FRONT;
  localparam int unsigned HS_END   = HS_START + DEF_H_SYNC - 1;
  localparam int unsigned VS_START = DEF_V_DISPLAY + DEF_V_FRONT;
  localparam int unsigned VS_END   = VS_START + DEF_V_SYNC - 1;

endpackage
`default_nettype wire

// File: rtl/vga_sync_gen_if.sv
`default_nettype none
// ============================================================================
// Interface   : vga_sync_gen_if
// Description : Timing bundle from the sync generator to the RGB selector and
//               the connector. No handshake: the consumer samples every clk.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   p_tick;
  logic   frame_start;
  coord_t pix_x;
  coord_t pix_y;

  modport master (output hsync, vsync, video_on, p_tick, frame_start, pix_x, pix_y);
  modport slave  (input  hsync, vsync, video_on, p_tick, frame_start, pix_x, pix_y);

endinterface
`default_nettype wire

// File: rtl/pixel_tick_div.sv
`default_nettype none
// ============================================================================
// Module      : pixel_tick_div
// Description : Divides clk by TICK_DIV (1..16) into a registered one-clk
//               pixel tick. With TICK_DIV=1 the tick stays high after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_tick_div #(
  parameter int unsigned TICK_DIV = 4
) (
  input  wire logic clk,
  input  wire logic reset,
  output logic      p_tick
);

  localparam int unsigned          c_CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_CNT_W-1:0]   c_LAST  = c_CNT_W'(TICK_DIV - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               r_tick;

  // Next divider count, wrapping after the last phase
  always_comb begin
    w_cnt_nxt = (r_cnt == c_LAST) ? '0 : r_cnt + c_CNT_W'(1);
  end

  // Tick register is high exactly while the count sits on its last phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tick <= (w_cnt_nxt == c_LAST);
    end
  end

  assign p_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA raster counters, visible-area decode and sync generation.
//               Outputs are registered from counter state; hsync/vsync get an
//               extra SYNC_DLY-stage delay to align with the registered RGB.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
  parameter int unsigned SYNC_DLY  = DEF_SYNC_DLY,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  wire logic      clk,
  input  wire logic      reset,
  vga_sync_gen_if.master vga
);

  localparam int unsigned c_H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned c_V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t c_H_LAST   = COORD_W'(c_H_TOTAL - 1);
  localparam coord_t c_V_LAST   = COORD_W'(c_V_TOTAL - 1);
  localparam coord_t c_H_DISP   = COORD_W'(H_DISPLAY);
  localparam coord_t c_V_DISP   = COORD_W'(V_DISPLAY);
  localparam coord_t c_HS_START = COORD_W'(H_DISPLAY + H_FRONT);
  localparam coord_t c_HS_END   = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t c_VS_START = COORD_W'(V_DISPLAY + V_FRONT);
  localparam coord_t c_VS_END   = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic   w_p_tick;
  coord_t r_h_cnt;
  coord_t r_v_cnt;
  coord_t r_pix_x;
  coord_t r_pix_y;
  logic   r_video_on;
  logic   r_frame_start;
  logic   r_hs_raw;
  logic   r_vs_raw;

  logic   w_video;
  logic   w_hs_act;
  logic   w_vs_act;
  logic   w_cnt_origin;
  logic   w_pix_origin;

  pixel_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk    (clk),
    .reset  (reset),
    .p_tick (w_p_tick)
  );

  // Raster counters: column steps once per pixel tick, row steps on column wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_p_tick) begin
      if (r_h_cnt == c_H_LAST) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + COORD_W'(1);
      end else begin
        r_h_cnt <= r_h_cnt + COORD_W'(1);
      end
    end
  end

  // Decode of the current counter position
  always_comb begin
    w_video      = (r_h_cnt < c_H_DISP) && (r_v_cnt < c_V_DISP);
    w_hs_act     = (r_h_cnt >= c_HS_START) && (r_h_cnt <= c_HS_END);
    w_vs_act     = (r_v_cnt >= c_VS_START) && (r_v_cnt <= c_VS_END);
    w_cnt_origin = (r_h_cnt == '0) && (r_v_cnt == '0);
    w_pix_origin = (r_pix_x == '0) && (r_pix_y == '0);
  end

  // Registered outputs; frame_start only fires when the origin is entered from
  // elsewhere, so the (0,0) held out of reset never pulses it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_video_on    <= 1'b0;
      r_frame_start <= 1'b0;
      r_hs_raw      <= ~SYNC_POL;
      r_vs_raw      <= ~SYNC_POL;
    end else begin
      r_pix_x       <= r_h_cnt;
      r_pix_y       <= r_v_cnt;
      r_video_on    <= w_video;
      r_frame_start <= w_cnt_origin && !w_pix_origin;
      r_hs_raw      <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vs_raw      <= w_vs_act ? SYNC_POL : ~SYNC_POL;
    end
  end

  generate
    if (SYNC_DLY > 0) begin : g_sync_dly
      logic [SYNC_DLY-1:0] r_hs_pipe;
      logic [SYNC_DLY-1:0] r_vs_pipe;

      // Sync delay line; every stage resets to the deasserted level
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_hs_pipe <= {SYNC_DLY{~SYNC_POL}};
          r_vs_pipe <= {SYNC_DLY{~SYNC_POL}};
        end else begin
          r_hs_pipe <= SYNC_DLY'({r_hs_pipe, r_hs_raw});
          r_vs_pipe <= SYNC_DLY'({r_vs_pipe, r_vs_raw});
        end
      end

      assign vga.hsync = r_hs_pipe[SYNC_DLY-1];
      assign vga.vsync = r_vs_pipe[SYNC_DLY-1];
    end else begin : g_sync_nodly
      assign vga.hsync = r_hs_raw;
      assign vga.vsync = r_vs_raw;
    end
  endgenerate

  assign vga.video_on    = r_video_on;
  assign vga.p_tick      = w_p_tick;
  assign vga.frame_start = r_frame_start;
  assign vga.pix_x       = r_pix_x;
  assign vga.pix_y       = r_pix_y;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Three sync generators (defaults, a small timing with
//               TICK_DIV=3/SYNC_DLY=2, a tiny timing with TICK_DIV=1,
//               SYNC_DLY=0, active-high sync) compared every clk against a
//               linear-pixel-index model, with random mid-frame resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

  typedef struct packed {
    int hd; int hf; int hs; int hb;
    int vd; int vf; int vs; int vb;
    int td; int dly; int pol;
  } cfg_t;

  localparam cfg_t C0 = '{640, 16, 96, 48, 480, 10, 2, 33, 4, 1, 0};
  localparam cfg_t C1 = '{20, 4, 6, 3, 12, 3, 2, 4, 3, 2, 0};
  localparam cfg_t C2 = '{16, 2, 4, 2, 8, 1, 2, 1, 1, 0, 1};
  localparam int   NCYC = 13000;

  logic clk = 1'b0;
  logic r_rst [3];

  always #5 clk = ~clk;

  vga_sync_gen_if u_if0 ();
  vga_sync_gen_if u_if1 ();
  vga_sync_gen_if u_if2 ();

  vga_sync_gen u_dut0 (.clk(clk), .reset(r_rst[0]), .vga(u_if0));

  vga_sync_gen #(
    .H_DISPLAY(C1.hd), .H_FRONT(C1.hf), .H_SYNC(C1.hs), .H_BACK(C1.hb),
    .V_DISPLAY(C1.vd), .V_FRONT(C1.vf), .V_SYNC(C1.vs), .V_BACK(C1.vb),
    .TICK_DIV(C1.td), .SYNC_DLY(C1.dly), .SYNC_POL(C1.pol != 0)
  ) u_dut1 (.clk(clk), .reset(r_rst[1]), .vga(u_if1));

  vga_sync_gen #(
    .H_DISPLAY(C2.hd), .H_FRONT(C2.hf), .H_SYNC(C2.hs), .H_BACK(C2.hb),
    .V_DISPLAY(C2.vd), .V_FRONT(C2.vf), .V_SYNC(C2.vs), .V_BACK(C2.vb),
    .TICK_DIV(C2.td), .SYNC_DLY(C2.dly), .SYNC_POL(C2.pol != 0)
  ) u_dut2 (.clk(clk), .reset(r_rst[2]), .vga(u_if2));

  // Observed outputs packed as {hsync, vsync, video_on, p_tick, frame_start, pix_x, pix_y}
  logic [31:0] w_obs [3];
  assign w_obs[0] = {7'd0, u_if0.hsync, u_if0.vsync, u_if0.video_on, u_if0.p_tick,
                     u_if0.frame_start, u_if0.pix_x, u_if0.pix_y};
  assign w_obs[1] = {7'd0, u_if1.hsync, u_if1.vsync, u_if1.video_on, u_if1.p_tick,
                     u_if1.frame_start, u_if1.pix_x, u_if1.pix_y};
  assign w_obs[2] = {7'd0, u_if2.hsync, u_if2.vsync, u_if2.video_on, u_if2.p_tick,
                     u_if2.frame_start, u_if2.pix_x, u_if2.pix_y};

  int n_vec = 0;
  int n_err = 0;

  // Model state: clocks since release, pixel steps taken, pixel index shown
  int m_n        [3];
  int m_steps    [3];
  int m_lin      [3];
  int m_lin_prev [3];
  bit m_ptick    [3];
  bit m_fs       [3];
  bit m_in_rst   [3];
  bit m_hist_h   [3][4];
  bit m_hist_v   [3][4];
  int rst_left   [3];

  int fs_last [3];
  int von_cnt [3];
  int vs_cnt  [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic cfg_t get_cfg(input int i);
    case (i)
      0:       return C0;
      1:       return C1;
      default: return C2;
    endcase
  endfunction

  task automatic model_clear(input int i);
    cfg_t c = get_cfg(i);
    m_n[i] = 0; m_steps[i] = 0; m_lin[i] = 0; m_lin_prev[i] = 0;
    m_ptick[i] = 1'b0; m_fs[i] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_hist_h[i][k] = (c.pol == 0);
      m_hist_v[i][k] = (c.pol == 0);
    end
    fs_last[i] = -1; von_cnt[i] = 0; vs_cnt[i] = 0;
  endtask

  // One clk edge: the shown pixel is the step count reached one clk earlier
  task automatic model_step(input int i);
    cfg_t c = get_cfg(i);
    int ht = c.hd + c.hf + c.hs + c.hb;
    int vt = c.vd + c.vf + c.vs + c.vb;
    int x, y;
    m_n[i]++;
    m_lin_prev[i] = m_lin[i];
    m_lin[i]      = m_steps[i];
    m_steps[i]   += m_ptick[i] ? 1 : 0;
    m_ptick[i]    = ((m_n[i] % c.td) == (c.td - 1));
    x = m_lin[i] % ht;
    y = (m_lin[i] / ht) % vt;
    for (int k = 3; k > 0; k--) begin
      m_hist_h[i][k] = m_hist_h[i][k-1];
      m_hist_v[i][k] = m_hist_v[i][k-1];
    end
    m_hist_h[i][0] = (x >= c.hd + c.hf && x < c.hd + c.hf + c.hs) ? (c.pol != 0) : (c.pol == 0);
    m_hist_v[i][0] = (y >= c.vd + c.vf && y < c.vd + c.vf + c.vs) ? (c.pol != 0) : (c.pol == 0);
    m_fs[i] = ((m_lin[i] % (ht * vt)) == 0) && (m_lin[i] != m_lin_prev[i]);
  endtask

  function automatic logic [31:0] exp_word(input int i);
    cfg_t c = get_cfg(i);
    int ht = c.hd + c.hf + c.hs + c.hb;
    int vt = c.vd + c.vf + c.vs + c.vb;
    logic [9:0] x, y;
    bit von;
    bit idle = (c.pol == 0);
    if (m_in_rst[i] || m_n[i] == 0)
      return {7'd0, idle, idle, 3'b000, 20'd0};
    x   = 10'(m_lin[i] % ht);
    y   = 10'((m_lin[i] / ht) % vt);
    von = (int'(x) < c.hd) && (int'(y) < c.vd);
    return {7'd0, m_hist_h[i][c.dly], m_hist_v[i][c.dly], von, m_ptick[i], m_fs[i], x, y};
  endfunction

  initial begin
    bit   done0   = 1'b0;
    bit   hs_done = 1'b0;
    int   hs_low  = 0;
    int   px_cyc  = -1;
    int   prev_px = 0;
    bit   prev_hs = 1'b1;
    cfg_t c;
    bit   want;
    int   dur;

    for (int i = 0; i < 3; i++) begin
      r_rst[i]    = 1'b0;
      m_in_rst[i] = 1'b1;
      rst_left[i] = 5;
      model_clear(i);
    end

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      for (int i = 0; i < 3; i++)
        if (!m_in_rst[i]) model_step(i);

      #2;
      for (int i = 0; i < 3; i++) begin
        if (m_in_rst[i]) begin
          if (rst_left[i] > 0) rst_left[i]--;
          if (rst_left[i] == 0) begin
            r_rst[i]    = 1'b1;
            m_in_rst[i] = 1'b0;
          end
        end else begin
          want = 1'b0;
          dur  = 1;
          if (i == 0) begin
            // Mid-hsync reset at pixel (700, 2)
            if (!done0 && m_n[0] > 0 && m_lin[0] == 2 * 800 + 700) begin
              want = 1'b1; dur = 3; done0 = 1'b1;
            end
          end else if (i == 1) begin
            if (cyc > 7000 && $urandom_range(0, 999) < 3) begin
              want = 1'b1; dur = $urandom_range(1, 4);
            end
          end else begin
            if (cyc > 400 && $urandom_range(0, 999) < 4) begin
              want = 1'b1; dur = $urandom_range(1, 4);
            end
          end
          if (want) begin
            r_rst[i]    = 1'b0;
            m_in_rst[i] = 1'b1;
            rst_left[i] = dur;
            model_clear(i);
          end
        end
      end

      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        c = get_cfg(i);
        check($sformatf("dut%0d_cyc%0d", i, cyc), w_obs[i], exp_word(i));
        if (m_in_rst[i]) begin
          fs_last[i] = -1; von_cnt[i] = 0; vs_cnt[i] = 0;
        end else begin
          if (w_obs[i][20]) begin
            if (fs_last[i] >= 0) begin
              check($sformatf("dut%0d_frame_period", i), 32'(cyc - fs_last[i]),
                    32'((c.hd + c.hf + c.hs + c.hb) * (c.vd + c.vf + c.vs + c.vb) * c.td));
              check($sformatf("dut%0d_video_on_per_frame", i), 32'(von_cnt[i]),
                    32'(c.hd * c.vd * c.td));
              check($sformatf("dut%0d_vsync_per_frame", i), 32'(vs_cnt[i]),
                    32'(c.vs * (c.hd + c.hf + c.hs + c.hb) * c.td));
            end
            fs_last[i] = cyc; von_cnt[i] = 0; vs_cnt[i] = 0;
          end
          if (w_obs[i][22]) von_cnt[i]++;
          if (w_obs[i][23] == (c.pol != 0)) vs_cnt[i]++;
        end
      end

      // Default-timing hsync: width over the first line and delay after pix_x=656
      if (!m_in_rst[0] && !hs_done && m_n[0] >= 1 && m_n[0] <= 3200) begin
        if (u_if0.hsync == 1'b0) hs_low++;
        if (m_n[0] == 3200) begin
          check("hsync_low_first_line", 32'(hs_low), 32'(C0.hs * C0.td));
          hs_done = 1'b1;
        end
      end
      if (int'(u_if0.pix_x) == 656 && prev_px != 656) px_cyc = cyc;
      if (u_if0.hsync == 1'b0 && prev_hs == 1'b1 && px_cyc >= 0) begin
        check("hsync_fall_delay", 32'(cyc - px_cyc), 32'(C0.dly));
        px_cyc = -1;
      end
      prev_px = int'(u_if0.pix_x);
      prev_hs = u_if0.hsync;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
